// File: rtl/lsu_sequencer.sv
// Load/store sequencer between the memory stage and a single-port data RAM.
// Splits word-crossing accesses in two and returns one response per request.
module lsu_sequencer #(
   parameter int MEM_AWIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_func3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_data,
   output logic                  resp_err,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [MEM_AWIDTH-1:0] mem_addr,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout
);

   typedef enum logic [2:0] {
      IDLE,
      ACC0,
      ACC1,
      CAP,
      RESP
   } state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            func3_q, func3_d;
   logic [1:0]            off_q, off_d;
   logic [MEM_AWIDTH-1:0] word_q, word_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  split_q, split_d;
   logic [31:0]           lo_q, lo_d;
   logic                  ready_q, ready_d;
   logic                  mem_en_q, mem_en_d;
   logic [3:0]            mem_we_q, mem_we_d;
   logic [MEM_AWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_din_q, mem_din_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [31:0]           resp_data_q, resp_data_d;
   logic                  resp_err_q, resp_err_d;

   logic                  accept;
   logic                  in_idle;
   logic                  cur_we;
   logic [2:0]            cur_f3;
   logic [1:0]            cur_off;
   logic [31:0]           cur_wdata;
   logic [3:0]            size_mask;
   logic [7:0]            lane8;
   logic [63:0]           wsh;
   logic                  cur_split;
   logic                  illegal;
   logic [63:0]           rd64;
   logic [63:0]           rsh;
   logic [31:0]           ext;
   logic                  unused_addr;

   assign unused_addr = ^req_addr[31:MEM_AWIDTH+2];

   assign accept  = req_valid & ready_q;
   assign in_idle = (state_q == IDLE);

   // Lane math is shared: in IDLE it serves ACC0 from the live request,
   // elsewhere it serves ACC1 from the latched copy.
   always_comb begin
      cur_we    = in_idle ? req_we        : we_q;
      cur_f3    = in_idle ? req_func3     : func3_q;
      cur_off   = in_idle ? req_addr[1:0] : off_q;
      cur_wdata = in_idle ? req_wdata     : wdata_q;
   end

   always_comb begin
      case (cur_f3[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   end

   assign lane8     = {4'b0000, size_mask} << cur_off;
   assign cur_split = |lane8[7:4];
   assign wsh       = {32'b0, cur_wdata} << {cur_off, 3'b000};

   always_comb begin
      case (req_func3)
         3'b011,
         3'b110,
         3'b111:  illegal = 1'b1;
         3'b100,
         3'b101:  illegal = req_we;
         default: illegal = 1'b0;
      endcase
   end

   assign rd64 = split_q ? {mem_dout, lo_q} : {32'b0, mem_dout};
   assign rsh  = rd64 >> {off_q, 3'b000};

   always_comb begin
      case (func3_q)
         3'b000:  ext = {{24{rsh[7]}}, rsh[7:0]};
         3'b001:  ext = {{16{rsh[15]}}, rsh[15:0]};
         3'b100:  ext = {24'b0, rsh[7:0]};
         3'b101:  ext = {16'b0, rsh[15:0]};
         default: ext = rsh[31:0];
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      func3_d      = func3_q;
      off_d        = off_q;
      word_d       = word_q;
      wdata_d      = wdata_q;
      split_d      = split_q;
      lo_d         = lo_q;
      ready_d      = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 4'b0000;
      mem_addr_d   = '0;
      mem_din_d    = 32'b0;
      resp_valid_d = 1'b0;
      resp_data_d  = 32'b0;
      resp_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            ready_d = ~accept;
            if (accept) begin
               we_d    = req_we;
               func3_d = req_func3;
               off_d   = req_addr[1:0];
               word_d  = req_addr[MEM_AWIDTH+1:2];
               wdata_d = req_wdata;
               split_d = cur_split;
               if (illegal) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d    = ACC0;
                  mem_en_d   = 1'b1;
                  mem_addr_d = req_addr[MEM_AWIDTH+1:2];
                  mem_we_d   = cur_we ? lane8[3:0] : 4'b0000;
                  mem_din_d  = cur_we ? wsh[31:0] : 32'b0;
               end
            end
         end
         ACC0: begin
            if (split_q) begin
               state_d    = ACC1;
               mem_en_d   = 1'b1;
               mem_addr_d = word_q + MEM_AWIDTH'(1);
               mem_we_d   = we_q ? lane8[7:4] : 4'b0000;
               mem_din_d  = we_q ? wsh[63:32] : 32'b0;
            end else if (we_q) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
            end else begin
               state_d = CAP;
            end
         end
         ACC1: begin
            lo_d = mem_dout;
            if (we_q) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
            end else begin
               state_d = CAP;
            end
         end
         CAP: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = ext;
         end
         RESP: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         func3_q      <= 3'b000;
         off_q        <= 2'b00;
         word_q       <= '0;
         wdata_q      <= 32'b0;
         split_q      <= 1'b0;
         lo_q         <= 32'b0;
         ready_q      <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 4'b0000;
         mem_addr_q   <= '0;
         mem_din_q    <= 32'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         func3_q      <= func3_d;
         off_q        <= off_d;
         word_q       <= word_d;
         wdata_q      <= wdata_d;
         split_q      <= split_d;
         lo_q         <= lo_d;
         ready_q      <= ready_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = ready_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: byte-level reference memory, directed
// cases then randomized requests with busy-time noise on the request port.
module tb_lsu_sequencer;

   localparam int AW = 14;
   localparam int NW = 1 << AW;
   localparam int NB = 1 << (AW + 2);

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_func3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_data;
   logic          resp_err;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_din;
   logic [31:0]   mem_dout;

   always #5 clk = ~clk;

   lsu_sequencer #(.MEM_AWIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_func3 (req_func3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_data (resp_data),
      .resp_err  (resp_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   logic [31:0]   tb_mem [0:NW-1];
   logic [31:0]   init_w [0:NW-1];
   logic [7:0]    ref_b  [0:NB-1];
   logic          load_mem;
   logic          poke_en;
   logic [AW-1:0] poke_a;
   logic [31:0]   poke_d;
   logic [AW-1:0] acc_addr [$];
   logic [3:0]    acc_we   [$];
   int            resp_cnt;
   int            checks;
   int            errors;

   initial begin
      mem_dout = 32'b0;
      resp_cnt = 0;
   end

   // Synchronous RAM model: read-first, byte-lane writes.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int w = 0; w < NW; w++) tb_mem[w] <= init_w[w];
      end else if (poke_en) begin
         tb_mem[poke_a] <= poke_d;
      end else if (mem_en) begin
         acc_addr.push_back(mem_addr);
         acc_we.push_back(mem_we);
         for (int i = 0; i < 4; i++)
            if (mem_we[i]) tb_mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
         mem_dout <= tb_mem[mem_addr];
      end
      if (resp_valid) resp_cnt <= resp_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f);
      if (f[1:0] == 2'b00) return 1;
      if (f[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit is_illegal(input logic we, input logic [2:0] f);
      if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
      if (we && (f == 3'd4 || f == 3'd5)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_word(input logic [AW-1:0] w);
      int b = int'(w) * 4;
      return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [15:0] ba,
                                            input logic [2:0] f);
      int n = nbytes(f);
      logic [31:0] v = 32'b0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[16'(ba + 16'(i))];
      if (!f[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic poke(input logic [AW-1:0] w, input logic [31:0] v);
      @(negedge clk);
      poke_en = 1'b1;
      poke_a  = w;
      poke_d  = v;
      for (int i = 0; i < 4; i++) ref_b[int'(w) * 4 + i] = v[8*i +: 8];
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got, output int lat);
      logic [15:0]   ba    = addr[15:0];
      logic [AW-1:0] wa    = addr[AW+1:2];
      logic [AW-1:0] wa1   = wa + AW'(1);
      int            n     = nbytes(f);
      int            o     = int'(addr[1:0]);
      bit            ill   = is_illegal(we, f);
      bit            split = (o + n) > 4;
      logic [7:0]    m8    = 8'b0;
      logic [31:0]   exp_d = 32'b0;
      int            exp_l;
      int            exp_n;
      int            rc0;
      for (int i = 0; i < n; i++) m8[o + i] = 1'b1;
      if (!ill && !we) exp_d = ref_load(ba, f);
      if (ill) exp_l = 1;
      else if (we) exp_l = split ? 3 : 2;
      else exp_l = split ? 4 : 3;
      exp_n = ill ? 0 : (split ? 2 : 1);
      if (!ill && we)
         for (int i = 0; i < n; i++) ref_b[16'(ba + 16'(i))] = wd[8*i +: 8];
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_func3 = f;
      req_addr  = addr;
      req_wdata = wd;
      acc_addr.delete();
      acc_we.delete();
      rc0 = resp_cnt;
      @(posedge clk);
      #1;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_func3 = 3'($urandom_range(0, 7));
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = 0;
      got = 32'hDEADDEAD;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = k;
            got = resp_data;
            chk("resp_err", 32'(resp_err), 32'(ill));
            req_valid = 1'b0;
            break;
         end
         req_valid = 1'($urandom_range(0, 1));
      end
      req_valid = 1'b0;
      chk("latency", 32'(lat), 32'(exp_l));
      chk("resp_data", got, exp_d);
      chk("acc_count", 32'(acc_addr.size()), 32'(exp_n));
      if (exp_n >= 1) begin
         chk("acc0_addr", acc_addr.size() > 0 ? 32'(acc_addr[0]) : '1,
             32'(wa));
         chk("acc0_we", acc_we.size() > 0 ? 32'(acc_we[0]) : '1,
             we ? 32'(m8[3:0]) : 32'd0);
      end
      if (exp_n == 2) begin
         chk("acc1_addr", acc_addr.size() > 1 ? 32'(acc_addr[1]) : '1,
             32'(wa1));
         chk("acc1_we", acc_we.size() > 1 ? 32'(acc_we[1]) : '1,
             we ? 32'(m8[7:4]) : 32'd0);
      end
      if (we) begin
         chk("mem_word0", tb_mem[wa], ref_word(wa));
         chk("mem_word1", tb_mem[wa1], ref_word(wa1));
      end
      @(negedge clk);
      chk("resp_pulse", 32'(resp_valid), 32'd0);
      chk("resp_count", 32'(resp_cnt - rc0), 32'd1);
      chk("ready_back", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] got;
      int          lat;
      int          rc0;
      logic [31:0] a;
      logic [2:0]  f;
      logic [2:0]  legal_f [5];
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_func3 = 3'b000;
      req_addr  = 32'b0;
      req_wdata = 32'b0;
      poke_en   = 1'b0;
      poke_a    = '0;
      poke_d    = 32'b0;
      legal_f   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int w = 0; w < NW; w++) begin
         init_w[w] = $urandom;
         for (int i = 0; i < 4; i++) ref_b[w*4 + i] = init_w[w][8*i +: 8];
      end
      load_mem = 1'b1;
      @(posedge clk);
      #1 load_mem = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_din", mem_din, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

      poke(14'h040, 32'h8BADF00D);
      do_req(1'b0, 3'd2, 32'h100, 32'h0, got, lat);
      chk("lw_const", got, 32'h8BADF00D);
      chk("lw_lat", 32'(lat), 32'd3);

      poke(14'h040, 32'h80123456);
      do_req(1'b0, 3'd0, 32'h103, 32'h0, got, lat);
      chk("lb_const", got, 32'hFFFFFF80);
      do_req(1'b0, 3'd4, 32'h103, 32'h0, got, lat);
      chk("lbu_const", got, 32'h00000080);
      do_req(1'b0, 3'd1, 32'h102, 32'h0, got, lat);
      chk("lh_const", got, 32'hFFFF8012);

      poke(14'h03F, 32'h44332211);
      poke(14'h040, 32'h88776655);
      do_req(1'b0, 3'd2, 32'h0FE, 32'h0, got, lat);
      chk("split_lw_const", got, 32'h66554433);
      chk("split_lw_lat", 32'(lat), 32'd4);

      do_req(1'b1, 3'd1, 32'h103, 32'h0000BEEF, got, lat);
      chk("split_sh_b3", 32'(tb_mem[14'h040][31:24]), 32'hEF);
      chk("split_sh_b0", 32'(tb_mem[14'h041][7:0]), 32'hBE);
      chk("split_sh_lat", 32'(lat), 32'd3);
      chk("split_sh_data", got, 32'd0);

      do_req(1'b0, 3'd2, 32'hFFFE, 32'h0, got, lat);
      do_req(1'b0, 3'd3, 32'h100, 32'h0, got, lat);
      chk("illegal_lat", 32'(lat), 32'd1);
      do_req(1'b1, 3'd4, 32'h100, 32'h12345678, got, lat);
      do_req(1'b1, 3'd2, 32'h200, 32'hCAFEF00D, got, lat);

      // Reset during the first half of a split store.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_func3 = 3'd2;
      req_addr  = 32'h101;
      req_wdata = 32'hA1B2C3D4;
      acc_addr.delete();
      acc_we.delete();
      rc0 = resp_cnt;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ready_low", 32'(req_ready), 32'd0);
      rst = 1'b0;
      ref_b[16'h101] = 8'hD4;
      ref_b[16'h102] = 8'hC3;
      ref_b[16'h103] = 8'hB2;
      @(posedge clk);
      #1 chk("abort_ready", 32'(req_ready), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_acc_n", 32'(acc_addr.size()), 32'd1);
      chk("abort_addr", acc_addr.size() > 0 ? 32'(acc_addr[0]) : '1,
          32'h40);
      chk("abort_we", acc_we.size() > 0 ? 32'(acc_we[0]) : '1,
          32'b1110);
      chk("abort_no_resp", 32'(resp_cnt - rc0), 32'd0);
      chk("abort_mem0", tb_mem[14'h040], ref_word(14'h040));
      chk("abort_mem1", tb_mem[14'h041], ref_word(14'h041));

      for (int t = 0; t < 300; t++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[15:3] = '1;
         if ($urandom_range(0, 7) == 0) f = 3'($urandom_range(0, 7));
         else f = legal_f[$urandom_range(0, 4)];
         do_req(1'($urandom_range(0, 1)), f, a, $urandom, got, lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
